alu_result_disp: RTL

ALU_RESULT_DISP -- requirements
Module: alu_result_disp

---
 rtl/alu_result_disp.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_result_disp.sv
// Seven-segment readout for a 5-bit signed ALU result with a function-code digit.
// A capture handshake holds each result on screen for a minimum time before accepting the next.
module alu_result_disp #(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [4:0] res_data,
    input  logic [2:0] res_func,
    output logic       res_ready,
    output logic [7:0] seg_o,
    output logic [3:0] an_o,
    output logic       neg_led
);

    // state | meaning
    // IDLE  | nothing captured yet, shows "----", ready for a result
    // HOLD  | result captured and shown, minimum display time running, not ready
    // SHOWN | result still shown, ready to replace it
    typedef enum logic [1:0] {IDLE, HOLD, SHOWN} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [4:0]  data_q, data_d;
    logic [2:0]  func_q, func_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic        capture;
    logic        scan_wrap;
    logic        neg;
    logic [4:0]  mag;
    logic        tens;
    logic [4:0]  units_w;
    logic [3:0]  units;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        logic [7:0] code;
        case (v)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    assign capture = res_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        data_d     = data_q;
        func_d     = func_q;
        case (state_q)
            IDLE, SHOWN: begin
                if (capture) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    data_d     = res_data;
                    func_d     = res_func;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = SHOWN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != HOLD);
    end

    // Magnitude is 5 bits wide so that -16 converts to 16 without wrapping.
    always_comb begin
        neg     = data_q[4];
        mag     = neg ? (5'd0 - data_q) : data_q;
        tens    = (mag >= 5'd10);
        units_w = tens ? (mag - 5'd10) : mag;
        units   = units_w[3:0];
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_wrap ? 16'd0 : (scan_cnt_q + 16'd1);
        dig_d      = scan_wrap ? (dig_q + 2'd1) : dig_q;
        an_d       = ~(4'b0001 << dig_d);
        if (state_q == IDLE) begin
            seg_d = SEG_DASH;
        end else begin
            case (dig_d)
                2'd0:    seg_d = seg_code(units);
                2'd1:    seg_d = tens ? seg_code(4'd1) : SEG_BLANK;
                2'd2:    seg_d = neg ? SEG_DASH : SEG_BLANK;
                default: seg_d = seg_code({1'b0, func_q});
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            hold_cnt_q <= '0;
            data_q     <= '0;
            func_q     <= '0;
            scan_cnt_q <= '0;
            dig_q      <= '0;
            an_q       <= 4'b1110;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            hold_cnt_q <= hold_cnt_d;
            data_q     <= data_d;
            func_q     <= func_d;
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign res_ready = ready_q;
    assign seg_o     = seg_q;
    assign an_o      = an_q;
    assign neg_led   = (state_q != IDLE) && data_q[4];

endmodule
